// File: rtl/dualportram_arbiter.sv
// dualportram_arbiter
//
// Shares a single dualportram port between two requesters, A and B.
// Arbitration is round-robin with a bounded burst length. RAM commands are
// registered, and read data comes back to the winning requester with a
// one-cycle tagged valid pulse.
//
// Parameters
//   WIDTH : data width, must match the RAM
//   BURST : max consecutive grants to one requester while the other waits (1..15)
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   req_x, we_x, address_x, din_x command from requester x (held until grant_x)
//   grant_x                       command accepted at the end of this cycle
//   rvalid_x, rdata_x             read data return for requester x
//   ram_we, ram_oe, ram_address,  registered command to the RAM port
//   ram_din
//   ram_dout                      RAM read data (registered inside the RAM)
module dualportram_arbiter #(
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             we_a,
  input  logic [31:0]      address_a,
  input  logic [WIDTH-1:0] din_a,
  output logic             grant_a,
  output logic             rvalid_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             req_b,
  input  logic             we_b,
  input  logic [31:0]      address_b,
  input  logic [WIDTH-1:0] din_b,
  output logic             grant_b,
  output logic             rvalid_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             ram_we,
  output logic             ram_oe,
  output logic [31:0]      ram_address,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
);

  localparam logic [3:0] BURST_CNT = 4'(BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  owner_t     owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  // last_b_q = 1 means B was served last, so A wins the next tie.
  logic       last_b_q, last_b_d;
  logic       sel_a, sel_b;

  logic             cmd_we;
  logic [31:0]      cmd_address;
  logic [WIDTH-1:0] cmd_din;

  // Read tag pipeline: stage 1 covers the RAM command cycle, stage 2 the
  // cycle in which the RAM presents its registered read data.
  logic tag1_valid, tag1_b;
  logic tag2_valid, tag2_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      cnt_q    <= 4'd0;
      last_b_q <= 1'b1;
    end else begin
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
    end
  end

  // Grant selection and next arbitration state. Grants are forced low while
  // reset is held so nothing can be accepted during reset.
  always_comb begin
    sel_a    = 1'b0;
    sel_b    = 1'b0;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    cnt_inc  = (cnt_q < BURST_CNT) ? cnt_q + 4'd1 : BURST_CNT;

    if (!reset) begin
      if (req_a && req_b) begin
        case (owner_q)
          OWN_A: begin
            if (cnt_q < BURST_CNT) sel_a = 1'b1;
            else                   sel_b = 1'b1;
          end
          OWN_B: begin
            if (cnt_q < BURST_CNT) sel_b = 1'b1;
            else                   sel_a = 1'b1;
          end
          default: begin
            if (last_b_q) sel_a = 1'b1;
            else          sel_b = 1'b1;
          end
        endcase
      end else begin
        sel_a = req_a;
        sel_b = req_b;
      end
    end

    if (sel_a) begin
      owner_d  = OWN_A;
      cnt_d    = (owner_q == OWN_A) ? cnt_inc : 4'd1;
      last_b_d = 1'b0;
    end else if (sel_b) begin
      owner_d  = OWN_B;
      cnt_d    = (owner_q == OWN_B) ? cnt_inc : 4'd1;
      last_b_d = 1'b1;
    end else begin
      owner_d = OWN_NONE;
      cnt_d   = 4'd0;
    end
  end

  assign grant_a = sel_a;
  assign grant_b = sel_b;

  assign cmd_we      = sel_b ? we_b      : we_a;
  assign cmd_address = sel_b ? address_b : address_a;
  assign cmd_din     = sel_b ? din_b     : din_a;

  // Address and data hold through idle cycles; only we/oe drop to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      ram_address <= 32'd0;
      ram_din     <= '0;
    end else if (sel_a || sel_b) begin
      ram_we      <= cmd_we;
      ram_oe      <= !cmd_we;
      ram_address <= cmd_address;
      ram_din     <= cmd_din;
    end else begin
      ram_we <= 1'b0;
      ram_oe <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag1_valid <= 1'b0;
      tag1_b     <= 1'b0;
      tag2_valid <= 1'b0;
      tag2_b     <= 1'b0;
    end else begin
      tag1_valid <= (sel_a || sel_b) && !cmd_we;
      tag1_b     <= sel_b;
      tag2_valid <= tag1_valid;
      tag2_b     <= tag1_b;
    end
  end

  assign rvalid_a = tag2_valid && !tag2_b;
  assign rvalid_b = tag2_valid &&  tag2_b;
  assign rdata_a  = ram_dout;
  assign rdata_b  = ram_dout;

endmodule

// File: tb/tb_dualportram_arbiter.sv
// Testbench for dualportram_arbiter: directed scenarios followed by
// randomized traffic, checked against a behavioural model with a read
// scoreboard consumed by an independent monitor.
module tb_dualportram_arbiter;

  localparam int WIDTH = 32;
  localparam int BURST = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_a, we_a, req_b, we_b;
  logic [31:0]      address_a, address_b;
  logic [WIDTH-1:0] din_a, din_b;
  logic             grant_a, grant_b, rvalid_a, rvalid_b;
  logic [WIDTH-1:0] rdata_a, rdata_b;
  logic             ram_we, ram_oe;
  logic [31:0]      ram_address;
  logic [WIDTH-1:0] ram_din, ram_dout;

  dualportram_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .address_a(address_a), .din_a(din_a),
    .grant_a(grant_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .address_b(address_b), .din_b(din_b),
    .grant_b(grant_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .ram_we(ram_we), .ram_oe(ram_oe), .ram_address(ram_address),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM port model: one registered read, 16 words, preloaded on its first edge.
  logic [31:0] ram_mem [16];
  logic [31:0] ram_q;
  bit          ram_loaded = 1'b0;

  function automatic logic [31:0] initWord(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hA5A50000 + 32'(i) * 32'h01010101);
  endfunction

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= initWord(i);
      ram_loaded <= 1'b1;
    end else begin
      if (ram_we) ram_mem[ram_address[3:0]] <= ram_din;
      if (ram_oe) ram_q <= ram_mem[ram_address[3:0]];
    end
  end
  assign ram_dout = ram_q;

  // Reference model state
  typedef struct {
    int          id;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] ref_mem [16];
  int          m_owner, m_cnt, m_last, last_win;
  logic        exp_we, exp_oe;
  logic [31:0] exp_addr, exp_din;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Winner per the arbitration rules: 0 = none, 1 = A, 2 = B.
  function automatic int pickWinner(input bit ra, input bit rb);
    if (!ra && !rb) return 0;
    if (ra && !rb)  return 1;
    if (rb && !ra)  return 2;
    if (m_owner != 0) return (m_cnt < BURST) ? m_owner : 3 - m_owner;
    return 3 - m_last;
  endfunction

  task automatic modelReset();
    m_owner = 0; m_cnt = 0; m_last = 2; last_win = 0;
    exp_we = 1'b0; exp_oe = 1'b0; exp_addr = 32'd0; exp_din = 32'd0;
    sb.delete();
  endtask

  // Drive one cycle of requests, check grant and RAM command registers,
  // then advance the model by what the arbiter should accept this cycle.
  task automatic applyStimulus(input bit ra, input bit wa, input logic [31:0] aa, input logic [31:0] da,
                               input bit rb, input bit wb, input logic [31:0] ab, input logic [31:0] db);
    int          w;
    logic        gwe;
    logic [31:0] gaddr, gdin;
    req_a = ra; we_a = wa; address_a = aa; din_a = da;
    req_b = rb; we_b = wb; address_b = ab; din_b = db;
    @(negedge clk);
    w = pickWinner(ra, rb);
    checkOutput("grant_a", grant_a, w == 1);
    checkOutput("grant_b", grant_b, w == 2);
    checkOutput("ram_we", ram_we, exp_we);
    checkOutput("ram_oe", ram_oe, exp_oe);
    checkOutput("ram_address", ram_address, exp_addr);
    checkOutput("ram_din", ram_din, exp_din);
    if (w != 0) begin
      gwe   = (w == 1) ? wa : wb;
      gaddr = (w == 1) ? aa : ab;
      gdin  = (w == 1) ? da : db;
      if (gwe) ref_mem[gaddr[3:0]] = gdin;
      else     sb.push_back('{w - 1, ref_mem[gaddr[3:0]], cyc + 2});
      exp_we = gwe; exp_oe = !gwe; exp_addr = gaddr; exp_din = gdin;
      m_cnt   = (w == m_owner) ? ((m_cnt < BURST) ? m_cnt + 1 : BURST) : 1;
      m_owner = w;
      m_last  = w;
    end else begin
      exp_we = 1'b0; exp_oe = 1'b0;
      m_owner = 0; m_cnt = 0;
    end
    last_win = w;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset asserted just after an edge; requests are held high to show
  // that grants stay forced low while reset is active.
  task automatic pulseReset(input int n);
    reset = 1'b1;
    req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
    modelReset();
    repeat (n) begin
      @(negedge clk);
      checkOutput("rst_grant_a", grant_a, 0);
      checkOutput("rst_grant_b", grant_b, 0);
      checkOutput("rst_ram_we", ram_we, 0);
      checkOutput("rst_ram_oe", ram_oe, 0);
      checkOutput("rst_ram_address", ram_address, 0);
      checkOutput("rst_ram_din", ram_din, 0);
      checkOutput("rst_rvalid_a", rvalid_a, 0);
      checkOutput("rst_rvalid_b", rvalid_b, 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding read.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checkOutput("rvalid_missing", 0, 1);
      void'(sb.pop_front());
    end
    if (rvalid_a && rvalid_b) begin
      checkOutput("rvalid_both", 1, 0);
    end else if (rvalid_a || rvalid_b) begin
      if (sb.size() == 0) begin
        checkOutput("rvalid_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("rvalid_id", {63'd0, rvalid_b}, e.id);
        checkOutput("rvalid_cycle", cyc, e.cyc);
        checkOutput("rdata", rvalid_b ? rdata_b : rdata_a, e.data);
        checkOutput("rdata_a_b_equal", rdata_a, rdata_b);
      end
    end
  end

  initial begin
    bit          pa, pb, wa, wb;
    logic [31:0] aa, ab, da, db;
    int          run, max_run, prev;

    for (int i = 0; i < 16; i++) ref_mem[i] = initWord(i);
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    address_a = 0; address_b = 0; din_a = 0; din_b = 0;
    reset = 1'b1;
    modelReset();
    @(posedge clk); #1;
    pulseReset(2);

    $display("[TB] single read");
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0);
    idle(3);

    $display("[TB] write then read");
    applyStimulus(1, 1, 9, 32'h12345678, 0, 0, 0, 0);
    idle(1);
    applyStimulus(0, 0, 0, 0, 1, 0, 9, 0);
    idle(3);

    $display("[TB] tie after reset");
    pulseReset(1);
    applyStimulus(1, 0, 1, 0, 1, 0, 2, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 2, 0);
    idle(3);

    $display("[TB] burst limit");
    run = 0; max_run = 0; prev = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 32'(i), 0, 1, 0, 32'(i + 6), 0);
      run = (last_win == prev) ? run + 1 : 1;
      prev = last_win;
      if (run > max_run) max_run = run;
    end
    checkOutput("burst_max_run", max_run, BURST);
    idle(3);

    $display("[TB] back-to-back reads");
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 32'(i), 0, 0, 0, 0, 0);
    idle(3);

    $display("[TB] reset mid-read");
    applyStimulus(1, 0, 3, 0, 0, 0, 0, 0);
    pulseReset(2);
    idle(4);
    applyStimulus(1, 0, 4, 0, 1, 0, 6, 0);
    idle(3);

    $display("[TB] random traffic");
    pa = 0; pb = 0; wa = 0; wb = 0; aa = 0; ab = 0; da = 0; db = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1; wa = 1'($urandom_range(0, 1));
        aa = 32'($urandom_range(0, 15)); da = $urandom;
      end
      if (!pb && $urandom_range(0, 3) != 0) begin
        pb = 1; wb = 1'($urandom_range(0, 1));
        ab = 32'($urandom_range(0, 15)); db = $urandom;
      end
      applyStimulus(pa, wa, aa, da, pb, wb, ab, db);
      if (last_win == 1) pa = 0;
      if (last_win == 2) pb = 0;
    end
    idle(4);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
